// File: rtl/coax_tx_sequencer.sv
// ---------------------------------------------------------------------------
// coax_tx_sequencer
//
// Transmit-side framing controller for the coax interface. Words arrive on a
// valid/ready handshake into a one-word holding register and are sent as
// Manchester-encoded frames:
//
//   [preamble: 5 x '1'] start(3 bits) {slot(12 bits)}* end(3 bits)
//
// A slot is: sync '1', data[9] .. data[0], even-parity bit.
// Symbol timing comes from an external coax_tx_bit_timer. This block holds
// that timer in reset while idle and advances one symbol on every
// timer_last_clock.
//
// Build option:
//   COAX_TX_SEQ_PREAMBLE_EN  defined   -> 5-bit line-quiesce preamble emitted
//                            undefined -> frame starts directly with START
//
// Parameters:
//   CLOCKS_PER_BIT     clocks per bit time (even, >= 4); must match the timer
//
// Ports:
//   clk                system clock, rising edge
//   reset_n            asynchronous active-low reset
//   data[9:0]          word to transmit, captured on accept
//   data_valid         data is presented
//   data_ready         holding register empty (accept = valid && ready)
//   tx                 line level
//   tx_active          high while a frame is on the line (line driver enable)
//   timer_reset        active-high reset to the bit timer
//   timer_second_half  bit timer is in the second half of the bit
//   timer_last_clock   bit timer is on the last clock of the bit
// ---------------------------------------------------------------------------
module coax_tx_sequencer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       tx_active,
  output logic       timer_reset,
  input  logic       timer_second_half,
  input  logic       timer_last_clock
);

  // The bit timer is external; the only thing this block can do with the
  // period is refuse an unusable one at elaboration.
  if (CLOCKS_PER_BIT < 4 || (CLOCKS_PER_BIT % 2) != 0) begin : g_cpb_invalid
    $error("coax_tx_sequencer: CLOCKS_PER_BIT must be even and >= 4");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
`ifdef COAX_TX_SEQ_PREAMBLE_EN
    S_PREAMBLE = 3'd1,
`endif
    S_START    = 3'd2,
    S_WORD     = 3'd3,
    S_END      = 3'd4
  } state_t;

  localparam logic [3:0] PREAMBLE_LAST = 4'd4;
  localparam logic [3:0] START_LAST    = 4'd2;
  localparam logic [3:0] WORD_LAST     = 4'd11;
  localparam logic [3:0] END_LAST      = 4'd2;

  // Manchester symbol for bit d: complement in the first half, true value in
  // the second half.
  function automatic logic manchester(input logic d, input logic second_half);
    return second_half ? d : ~d;
  endfunction

  // Control state (reset)
  state_t     state, state_nx;
  logic [3:0] bit_idx, bit_idx_nx;
  logic       hold_full;

  // Data path (no reset; only observed once loaded)
  logic [9:0] hold;
  logic [9:0] shreg;
  logic       parity;

  logic accept;
  logic load;
  logic shift;

  assign data_ready = !hold_full;
  assign accept     = data_valid && !hold_full;

  // Next-state / sequencing
  always_comb begin
    state_nx   = state;
    bit_idx_nx = bit_idx;
    load       = 1'b0;
    shift      = 1'b0;

    case (state)
      S_IDLE: begin
        bit_idx_nx = 4'd0;
        if (hold_full) begin
`ifdef COAX_TX_SEQ_PREAMBLE_EN
          state_nx = S_PREAMBLE;
`else
          state_nx = S_START;
`endif
        end
      end

`ifdef COAX_TX_SEQ_PREAMBLE_EN
      S_PREAMBLE: begin
        if (timer_last_clock) begin
          if (bit_idx == PREAMBLE_LAST) begin
            state_nx   = S_START;
            bit_idx_nx = 4'd0;
          end else begin
            bit_idx_nx = bit_idx + 4'd1;
          end
        end
      end
`endif

      S_START: begin
        if (timer_last_clock) begin
          if (bit_idx == START_LAST) begin
            // hold_full is still set from IDLE: nothing can clear it before
            // this load.
            state_nx   = S_WORD;
            bit_idx_nx = 4'd0;
            load       = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 4'd1;
          end
        end
      end

      S_WORD: begin
        if (timer_last_clock) begin
          if (bit_idx == WORD_LAST) begin
            bit_idx_nx = 4'd0;
            if (hold_full) begin
              // Next slot follows with no idle bit in between.
              load = 1'b1;
            end else begin
              state_nx = S_END;
            end
          end else begin
            bit_idx_nx = bit_idx + 4'd1;
            // Bits 1..10 carry data; step to the next data bit once one ends.
            shift = (bit_idx >= 4'd1) && (bit_idx <= 4'd10);
          end
        end
      end

      S_END: begin
        if (timer_last_clock) begin
          if (bit_idx == END_LAST) begin
            state_nx   = S_IDLE;
            bit_idx_nx = 4'd0;
          end else begin
            bit_idx_nx = bit_idx + 4'd1;
          end
        end
      end

      default: begin
        state_nx   = S_IDLE;
        bit_idx_nx = 4'd0;
      end
    endcase
  end

  // Line outputs are decoded from registered state, so the asynchronous
  // reset takes tx and tx_active low immediately.
  always_comb begin
    tx          = 1'b0;
    tx_active   = (state != S_IDLE);
    timer_reset = (state == S_IDLE);

    case (state)
`ifdef COAX_TX_SEQ_PREAMBLE_EN
      S_PREAMBLE: tx = manchester(1'b1, timer_second_half);
`endif
      S_START: begin
        // high/high, high/low, low/low: a pattern Manchester data never makes
        case (bit_idx)
          4'd0:    tx = 1'b1;
          4'd1:    tx = ~timer_second_half;
          default: tx = 1'b0;
        endcase
      end
      S_WORD: begin
        if (bit_idx == 4'd0) begin
          tx = manchester(1'b1, timer_second_half);
        end else if (bit_idx == WORD_LAST) begin
          tx = manchester(parity, timer_second_half);
        end else begin
          tx = manchester(shreg[9], timer_second_half);
        end
      end
      S_END: begin
        case (bit_idx)
          4'd0:    tx = manchester(1'b0, timer_second_half);
          4'd1:    tx = 1'b1;
          default: tx = 1'b0;
        endcase
      end
      default: tx = 1'b0;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_idx   <= 4'd0;
      hold_full <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_idx <= bit_idx_nx;
      // load and accept never coincide: load needs hold_full, accept needs
      // it clear.
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

  // Holding register, shift register and running parity
  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= data;
    end
    if (load) begin
      shreg  <= hold;
      parity <= 1'b0;
    end else if (shift) begin
      shreg  <= {shreg[8:0], 1'b0};
      parity <= parity ^ shreg[9];
    end
  end

endmodule
